// File: rtl/imp_dma_pkg.sv
// Shared types for the IMP DMA line sequencer: FSM states, latched job
// configuration and the pixel-count width.
package imp_dma_pkg;

    localparam int IMP_LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ISSUE,
        DRAIN
    } imp_seq_state_e;

    typedef struct packed {
        logic [31:0]          baddr;
        logic [31:0]          pitch;
        logic [IMP_LEN_W-1:0] hsize;
        logic [IMP_LEN_W-1:0] vsize;
        logic [IMP_LEN_W-1:0] minx;
        logic [IMP_LEN_W-1:0] miny;
    } imp_cfg_t;

endpackage

// File: rtl/imp_line_addr_gen.sv
// Line start-address generator: loads the first-line address of a job
// (base + row offset + column offset) and advances it by one pitch per line.
module imp_line_addr_gen #(
    parameter int ADDR_WIDTH    = 32,
    parameter int BYTES_PER_PIX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [31:0]           i_baddr,
    input  logic [31:0]           i_pitch,
    input  logic [7:0]            i_minx,
    input  logic [7:0]            i_miny,
    output logic [ADDR_WIDTH-1:0] o_line_addr
);

    logic [ADDR_WIDTH-1:0] r_line_addr;
    logic [ADDR_WIDTH-1:0] w_pitch;
    logic [ADDR_WIDTH-1:0] w_row_off;
    logic [ADDR_WIDTH-1:0] w_col_off;
    logic [ADDR_WIDTH-1:0] w_first_addr;

    // All terms are truncated to the address width, so the sum wraps naturally.
    assign w_pitch      = ADDR_WIDTH'(i_pitch);
    assign w_row_off    = w_pitch * ADDR_WIDTH'(i_miny);
    assign w_col_off    = ADDR_WIDTH'(i_minx) * ADDR_WIDTH'(BYTES_PER_PIX);
    assign w_first_addr = ADDR_WIDTH'(i_baddr) + w_row_off + w_col_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_addr <= '0;
        end else if (i_load) begin
            r_line_addr <= w_first_addr;
        end else if (i_step) begin
            r_line_addr <= r_line_addr + w_pitch;
        end
    end

    assign o_line_addr = r_line_addr;

endmodule

// File: rtl/imp_dma_seq_ctrl.sv
// IMP DMA job sequencer: latches the frame configuration on a start edge and
// issues one line command per row, bounding the number of in-flight lines.
module imp_dma_seq_ctrl
    import imp_dma_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int BYTES_PER_PIX   = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           cfg_baddr_i,
    input  logic [31:0]           cfg_pitch_i,
    input  logic [IMP_LEN_W-1:0]  cfg_hsize_i,
    input  logic [IMP_LEN_W-1:0]  cfg_vsize_i,
    input  logic [IMP_LEN_W-1:0]  cfg_minx_i,
    input  logic [IMP_LEN_W-1:0]  cfg_miny_i,
    input  logic                  cfg_start_i,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [ADDR_WIDTH-1:0] cmd_addr_o,
    output logic [IMP_LEN_W-1:0]  cmd_len_o,
    output logic                  cmd_last_o,
    input  logic                  cmd_done_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    input  logic                  err_clr_i
);

    localparam int OUT_W = 4;
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    imp_seq_state_e         r_state;
    imp_cfg_t               r_cfg;
    logic                   r_start_q;
    logic [IMP_LEN_W-1:0]   r_rows_left;
    logic [OUT_W-1:0]       r_outstanding;
    logic                   r_done;
    logic                   r_err;

    logic                   w_edge;
    logic                   w_zero_job;
    logic                   w_valid;
    logic                   w_hs;
    logic                   w_spurious;
    logic                   w_done_ok;
    logic                   w_err_set;
    logic [OUT_W-1:0]       w_out_next;
    logic [ADDR_WIDTH-1:0]  w_line_addr;

    assign w_edge     = cfg_start_i & ~r_start_q;
    assign w_zero_job = (cfg_hsize_i == '0) || (cfg_vsize_i == '0);
    assign w_valid    = (r_state == ISSUE) && (r_outstanding < MAX_OUT);
    assign w_hs       = w_valid & cmd_ready_i;
    // A completion with nothing in flight cannot belong to this job.
    assign w_spurious = cmd_done_i && (r_outstanding == '0);
    assign w_done_ok  = cmd_done_i && !w_spurious;
    assign w_err_set  = w_spurious || ((r_state == IDLE) && w_edge && w_zero_job);

    always_comb begin
        w_out_next = r_outstanding;
        if (w_hs && !w_done_ok) begin
            w_out_next = r_outstanding + OUT_W'(1);
        end else if (!w_hs && w_done_ok) begin
            w_out_next = r_outstanding - OUT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cfg         <= '0;
            r_start_q     <= 1'b1;
            r_rows_left   <= '0;
            r_outstanding <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_start_q     <= cfg_start_i;
            r_outstanding <= w_out_next;
            r_done        <= 1'b0;

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_edge) begin
                        r_cfg <= '{baddr: cfg_baddr_i, pitch: cfg_pitch_i,
                                   hsize: cfg_hsize_i, vsize: cfg_vsize_i,
                                   minx:  cfg_minx_i,  miny:  cfg_miny_i};
                        if (w_zero_job) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rows_left <= r_cfg.vsize;
                    r_state     <= ISSUE;
                end
                ISSUE: begin
                    if (w_hs) begin
                        r_rows_left <= r_rows_left - IMP_LEN_W'(1);
                        if (r_rows_left == IMP_LEN_W'(1)) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // done_o lands while still in DRAIN, so busy covers it and
                    // a start edge in that cycle is ignored.
                    if (r_outstanding == '0) begin
                        r_state <= IDLE;
                    end else if (w_out_next == '0) begin
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    imp_line_addr_gen #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .BYTES_PER_PIX (BYTES_PER_PIX)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .i_load      (r_state == CALC),
        .i_step      (w_hs),
        .i_baddr     (r_cfg.baddr),
        .i_pitch     (r_cfg.pitch),
        .i_minx      (r_cfg.minx),
        .i_miny      (r_cfg.miny),
        .o_line_addr (w_line_addr)
    );

    assign cmd_valid_o = w_valid;
    assign cmd_addr_o  = w_line_addr;
    assign cmd_len_o   = r_cfg.hsize;
    assign cmd_last_o  = (r_state == ISSUE) && (r_rows_left == IMP_LEN_W'(1));
    assign busy_o      = (r_state != IDLE);
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule

// File: tb/tb_imp_dma_seq_ctrl.sv
// Self-checking bench for imp_dma_seq_ctrl: directed steps plus random jobs,
// checked against a per-row address model and an in-flight line count.
module tb_imp_dma_seq_ctrl;

    localparam int BPP  = 4;
    localparam int MAXO = 4;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic        last;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_baddr_i, cfg_pitch_i;
    logic [7:0]  cfg_hsize_i, cfg_vsize_i, cfg_minx_i, cfg_miny_i;
    logic        cfg_start_i, cmd_valid_o, cmd_ready_i, cmd_last_o, cmd_done_i;
    logic [31:0] cmd_addr_o;
    logic [7:0]  cmd_len_o;
    logic        busy_o, done_o, err_o, err_clr_i;

    always #5 clk = ~clk;

    imp_dma_seq_ctrl #(
        .ADDR_WIDTH (32), .BYTES_PER_PIX (BPP), .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk (clk), .rst (rst),
        .cfg_baddr_i (cfg_baddr_i), .cfg_pitch_i (cfg_pitch_i),
        .cfg_hsize_i (cfg_hsize_i), .cfg_vsize_i (cfg_vsize_i),
        .cfg_minx_i (cfg_minx_i), .cfg_miny_i (cfg_miny_i),
        .cfg_start_i (cfg_start_i),
        .cmd_valid_o (cmd_valid_o), .cmd_ready_i (cmd_ready_i),
        .cmd_addr_o (cmd_addr_o), .cmd_len_o (cmd_len_o), .cmd_last_o (cmd_last_o),
        .cmd_done_i (cmd_done_i), .busy_o (busy_o), .done_o (done_o),
        .err_o (err_o), .err_clr_i (err_clr_i)
    );

    int   n_cmp = 0, n_err = 0;
    int   cyc = 0, hs_cnt = 0, done_cnt = 0, model_out = 0;
    int   last_zero_cyc = 0, last_due = 0, lat_min = 1, lat_max = 4;
    bit   auto_mode = 0, ready_all = 0, job_nonzero = 0, hold_pending = 0;
    cmd_t hold_cmd;
    cmd_t exp_q[$];
    int   due_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Master model: random ready, in-order completions after a random latency.
    task automatic respond();
        if (auto_mode) begin
            cmd_ready_i = ready_all ? 1'b1 : ($urandom_range(0, 3) != 0);
            cmd_done_i  = 1'b0;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                cmd_done_i = 1'b1;
                void'(due_q.pop_front());
            end
        end
    endtask

    task automatic monitor();
        cmd_t e;
        int   due;
        if (busy_o && model_out >= MAXO) chk("limit_valid_low", 64'(cmd_valid_o), 64'(0));
        if (hold_pending) begin
            chk("hold_valid", 64'(cmd_valid_o), 64'(1));
            chk("hold_addr",  64'(cmd_addr_o),  64'(hold_cmd.addr));
            chk("hold_len",   64'(cmd_len_o),   64'(hold_cmd.len));
            chk("hold_last",  64'(cmd_last_o),  64'(hold_cmd.last));
        end
        if (done_o) begin
            done_cnt++;
            chk("done_all_returned", 64'(model_out), 64'(0));
            chk("done_all_issued", 64'(exp_q.size()), 64'(0));
            if (job_nonzero) chk("done_latency", 64'(cyc), 64'(last_zero_cyc + 1));
        end
        if (cmd_valid_o && cmd_ready_i) begin
            hs_cnt++;
            chk("cmd_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cmd_addr", 64'(cmd_addr_o), 64'(e.addr));
                chk("cmd_len",  64'(cmd_len_o),  64'(e.len));
                chk("cmd_last", 64'(cmd_last_o), 64'(e.last));
            end
            model_out++;
            if (auto_mode) begin
                due = cyc + int'($urandom_range(lat_min, lat_max));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                due_q.push_back(due);
            end
        end
        if (cmd_done_i && model_out > 0) begin
            model_out--;
            if (model_out == 0) last_zero_cyc = cyc;
        end
        hold_pending  = cmd_valid_o && !cmd_ready_i;
        hold_cmd.addr = cmd_addr_o;
        hold_cmd.len  = cmd_len_o;
        hold_cmd.last = cmd_last_o;
    endtask

    task automatic step();
        respond();
        monitor();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(cmd_valid_o), 64'(0));
        chk({tag, "_addr"},  64'(cmd_addr_o),  64'(0));
        chk({tag, "_len"},   64'(cmd_len_o),   64'(0));
        chk({tag, "_last"},  64'(cmd_last_o),  64'(0));
        chk({tag, "_busy"},  64'(busy_o),      64'(0));
        chk({tag, "_done"},  64'(done_o),      64'(0));
        chk({tag, "_err"},   64'(err_o),       64'(0));
    endtask

    task automatic expect_rows(input logic [31:0] b, p, input logic [7:0] h, v, mx, my);
        cmd_t e;
        for (int r = 0; r < int'(v); r++) begin
            e.addr = b + (32'(my) + 32'(r)) * p + 32'(mx) * 32'(BPP);
            e.len  = h;
            e.last = (r == int'(v) - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic set_cfg(input logic [31:0] b, p, input logic [7:0] h, v, mx, my);
        cfg_baddr_i = b; cfg_pitch_i = p; cfg_hsize_i = h;
        cfg_vsize_i = v; cfg_minx_i = mx; cfg_miny_i = my;
    endtask

    task automatic run_job(input logic [31:0] b, p, input logic [7:0] h, v, mx, my, input bit toggle);
        int n;
        expect_rows(b, p, h, v, mx, my);
        done_cnt = 0; job_nonzero = 1;
        set_cfg(b, p, h, v, mx, my);
        cfg_start_i = 1'b1;
        step();
        chk("start_busy", 64'(busy_o), 64'(1));
        chk("start_calc_no_valid", 64'(cmd_valid_o), 64'(0));
        cfg_start_i = 1'b0;
        set_cfg($urandom, $urandom, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        step();
        chk("first_valid_latency", 64'(cmd_valid_o), 64'(1));
        n = 0;
        while (done_cnt == 0 && n < 2000) begin
            if (toggle && n == 2 && busy_o) cfg_start_i = 1'b1;
            if (n == 4) cfg_start_i = 1'b0;
            step();
            n++;
        end
        cfg_start_i = 1'b0;
        chk("job_done_within_bound", 64'(done_cnt), 64'(1));
        repeat (4) step();
        chk("done_single_pulse", 64'(done_cnt), 64'(1));
        chk("job_all_cmds", 64'(exp_q.size()), 64'(0));
        chk("idle_after_job", 64'(busy_o), 64'(0));
        $display("job base=0x%08h pitch=0x%0h h=%0d v=%0d minx=%0d miny=%0d toggle=%0d handshakes=%0d",
                 b, p, h, v, mx, my, toggle, hs_cnt);
    endtask

    initial begin
        rst = 1'b1; cfg_start_i = 1'b1; cmd_ready_i = 1'b0; cmd_done_i = 1'b0; err_clr_i = 1'b0;
        set_cfg(32'h0, 32'h0, 8'd4, 8'd4, 8'd0, 8'd0);
        @(negedge clk);
        repeat (3) step();
        check_all_zero("reset");

        // Start level held high through reset must not launch a job.
        rst = 1'b0;
        repeat (6) step();
        chk("start_held_no_busy", 64'(busy_o), 64'(0));
        chk("start_held_no_valid", 64'(cmd_valid_o), 64'(0));
        cfg_start_i = 1'b0;
        step();

        auto_mode = 1; ready_all = 1; lat_min = 2; lat_max = 2;
        run_job(32'h0000_1000, 32'd16, 8'd4, 8'd6, 8'd0, 8'd0, 1'b0);
        ready_all = 0; lat_min = 1; lat_max = 6;
        run_job(32'h0000_2000, 32'd64, 8'd7, 8'd2, 8'd2, 8'd3, 1'b1);
        run_job(32'hFFFF_FFF0, 32'd16, 8'd9, 8'd3, 8'd0, 8'd0, 1'b0);
        for (int j = 0; j < 16; j++) begin
            run_job($urandom, (j % 2 == 0) ? 32'($urandom_range(0, 4096)) : $urandom,
                    8'($urandom_range(1, 255)), 8'($urandom_range(1, 10)),
                    8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // Zero-size jobs: immediate done plus error.
        for (int z = 0; z < 2; z++) begin
            job_nonzero = 0; done_cnt = 0;
            set_cfg(32'h4000, 32'd32, (z == 0) ? 8'd5 : 8'd0, (z == 0) ? 8'd0 : 8'd5, 8'd0, 8'd0);
            cfg_start_i = 1'b1;
            step();
            chk("zero_done", 64'(done_o), 64'(1));
            chk("zero_err", 64'(err_o), 64'(1));
            chk("zero_not_busy", 64'(busy_o), 64'(0));
            chk("zero_no_valid", 64'(cmd_valid_o), 64'(0));
            cfg_start_i = 1'b0;
            step();
            chk("zero_done_pulse", 64'(done_o), 64'(0));
            chk("zero_done_count", 64'(done_cnt), 64'(1));
            err_clr_i = 1'b1;
            step();
            err_clr_i = 1'b0;
            chk("err_cleared", 64'(err_o), 64'(0));
            $display("zero-size job hsize=%0d vsize=%0d err cleared", cfg_hsize_i, cfg_vsize_i);
        end

        auto_mode = 0; cmd_ready_i = 1'b0;
        cmd_done_i = 1'b1;
        step();
        cmd_done_i = 1'b0;
        chk("spurious_done_err", 64'(err_o), 64'(1));
        cmd_done_i = 1'b1; err_clr_i = 1'b1;
        step();
        cmd_done_i = 1'b0; err_clr_i = 1'b0;
        chk("err_set_beats_clear", 64'(err_o), 64'(1));
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        chk("err_clear_again", 64'(err_o), 64'(0));

        // Backpressure: no completions, so issue stops at the outstanding limit.
        job_nonzero = 1; cmd_ready_i = 1'b1;
        begin
            int hs0;
            hs0 = hs_cnt;
            expect_rows(32'h0000_3000, 32'h100, 8'd16, 8'd8, 8'd1, 8'd1);
            set_cfg(32'h0000_3000, 32'h100, 8'd16, 8'd8, 8'd1, 8'd1);
            cfg_start_i = 1'b1;
            step();
            cfg_start_i = 1'b0;
            repeat (8) step();
            chk("bp_four_handshakes", 64'(hs_cnt - hs0), 64'(4));
            chk("bp_valid_low", 64'(cmd_valid_o), 64'(0));
            cmd_done_i = 1'b1;
            step();
            cmd_done_i = 1'b0;
            repeat (4) step();
            chk("bp_one_release", 64'(hs_cnt - hs0), 64'(5));
            chk("bp_valid_low_again", 64'(cmd_valid_o), 64'(0));
            cmd_done_i = 1'b1;
            repeat (2) step();
            cmd_done_i = 1'b0;
            repeat (4) step();
            chk("bp_coincident_done", 64'(hs_cnt - hs0), 64'(7));
            chk("bp_capped_at_limit", 64'(cmd_valid_o), 64'(0));
            chk("bp_still_busy", 64'(busy_o), 64'(1));
            $display("backpressure handshakes=%0d in_flight=%0d", hs_cnt - hs0, model_out);
        end

        // Reset while in ISSUE, then a late completion counts as spurious.
        rst = 1'b1;
        step();
        check_all_zero("mid_job_reset");
        rst = 1'b0;
        exp_q.delete(); due_q.delete(); model_out = 0; hold_pending = 0;
        cmd_done_i = 1'b1;
        step();
        cmd_done_i = 1'b0;
        chk("late_done_after_reset_err", 64'(err_o), 64'(1));
        chk("late_done_no_busy", 64'(busy_o), 64'(0));
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
